vram_dp_be: RTL and testbench
=============================

VRAM_DP_BE -- requirements
Module: vram_dp_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning word address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning read latency in cycles (legal 1 or 2).
REQ-004 SHALL have parameter RDW_NEW, default 0, meaning same-port read-during-write returns new data when 1 and old data when 0.
REQ-005 SHALL have ports clock (in, 1, sole clock) and reset (in, 1, asynchronous active-high reset).
REQ-006 SHALL have port A ports: rden_a, wren_a (in, 1); byteena_a (in, DATA_W/8); address_a (in, ADDR_W); data_a (in, DATA_W); q_a (out, DATA_W); qvalid_a (out, 1).
REQ-007 SHALL have port B ports rden_b, wren_b, byteena_b, address_b, data_b, q_b and qvalid_b, identical in direction and width to port A.
REQ-008 SHALL have ports clr_req (in, 1, start a memory clear), clr_busy (out, 1, clear in progress) and collision (out, 1, one-cycle same-address write-conflict flag).

Function
REQ-009 SHALL update, on a write, only the bytes whose byteena bit is 1; all other bytes SHALL hold.
REQ-010 SHALL give each port a read pipeline: q and qvalid appear RD_LAT cycles after the clock edge that samples rden=1.
REQ-011 SHALL deassert qvalid in every cycle whose corresponding rden was 0; q SHALL hold its last value in those cycles.
REQ-012 SHALL return, when RDW_NEW=1 and a port reads and writes one address in the same cycle, the merged word: written bytes new, others old.
REQ-013 SHALL return, when RDW_NEW=0 in that same-port case, the pre-write word.
REQ-014 SHALL return, for a cross-port read of an address written by the other port in the same cycle, the pre-write word, whatever RDW_NEW is.
REQ-015 SHALL resolve simultaneous writes by both ports to the same address per byte: where both byteena bits are set, port A data wins; elsewhere each port's enabled bytes are written.
REQ-016 SHALL pulse collision high for exactly one cycle (the cycle after the edge) when both ports write the same address with overlapping byteena.
REQ-017 SHALL implement a clear FSM with states IDLE and CLEAR.
REQ-018 SHALL move the FSM from IDLE to CLEAR when clr_req=1 is sampled.
REQ-019 SHALL, in CLEAR, write zero to one word per cycle, address counter 0 up to 2^ADDR_W-1, then return to IDLE.
REQ-020 SHALL hold clr_busy=1 exactly while the FSM is in CLEAR, i.e. 2^ADDR_W cycles.
REQ-021 SHALL ignore clr_req while in CLEAR; the clear does not restart.
REQ-022 SHALL ignore all port writes during CLEAR; collision SHALL stay 0 then.
REQ-023 SHALL still accept port reads during CLEAR; a read returns the word's current value, zero once that word has been cleared.
REQ-024 SHALL wrap addresses modulo 2^ADDR_W; no out-of-range access is possible.

Reset
REQ-025 SHALL, on reset=1, asynchronously force q_a=0, q_b=0, qvalid_a=0, qvalid_b=0, collision=0, clr_busy=0, FSM=IDLE and clear counter=0.
REQ-026 SHALL NOT alter memory contents on reset.
REQ-027 SHALL abort a CLEAR in progress on reset, leaving already-cleared words at zero and the remaining words unchanged.
REQ-028 SHALL flush in-flight read pipeline stages on reset; no qvalid pulse appears after reset is released.

Verification
REQ-029 SHALL pass byte-enable merge: write A 0x11223344 @0x10, then A data 0xAABBCCDD byteena=0b0101 @0x10, read B @0x10 -> 0x11BB33DD.
REQ-030 SHALL pass collision: same cycle, A writes 0xFFFFFFFF be=0b0011 @5 and B writes 0x00000000 be=0b0110 @5 -> word @5 = 0x??00FFFF (byte1 from A), collision=1 for one cycle.
REQ-031 SHALL pass read-during-write in both modes: @7 holds 0x1; A writes 0x2 @7 with rden_a=1 -> q_a=0x2 when RDW_NEW=1, 0x1 when RDW_NEW=0, each at RD_LAT cycles with qvalid_a=1.
REQ-032 SHALL pass full clear (ADDR_W=4): fill all 16 words nonzero, pulse clr_req -> clr_busy high for exactly 16 cycles, writes in that window dropped, then all reads = 0.
REQ-033 SHALL pass reset mid-clear (ADDR_W=4): assert reset after 6 clear cycles -> words 0..5 = 0, words 6..15 keep prior values, clr_busy=0, qvalid=0.
REQ-034 SHALL pass latency check with RD_LAT=2: back-to-back reads @1,@2,@3 -> q_b sequence appears on cycles +2,+3,+4 with qvalid_b high for exactly 3 cycles.

Source files
------------

// File: rtl/vram_dp_be.sv
// Dual-port byte-enabled video RAM with a background clear engine.
// Port A wins per-byte on same-address write conflicts; reads are pipelined
// by RD_LAT (1 or 2) cycles and flushed on reset; memory itself is never reset.
module vram_dp_be #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RDW_NEW = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rden_a,
  input  logic                wren_a,
  input  logic [DATA_W/8-1:0] byteena_a,
  input  logic [ADDR_W-1:0]   address_a,
  input  logic [DATA_W-1:0]   data_a,
  output logic [DATA_W-1:0]   q_a,
  output logic                qvalid_a,
  input  logic                rden_b,
  input  logic                wren_b,
  input  logic [DATA_W/8-1:0] byteena_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic [DATA_W-1:0]   q_b,
  output logic                qvalid_b,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                collision
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_busy_q, clr_busy_d;
  logic                collision_q, collision_d;

  logic                clearing_c;
  logic                wr_a_c, wr_b_c, same_addr_c;
  logic [NBYTES-1:0]   be_a_c, be_b_c;
  logic [DATA_W-1:0]   old_a_c, old_b_c, new_a_c, new_b_c;

  logic [1:0]              s1_vld_q, s1_vld_d;
  logic [1:0][DATA_W-1:0]  s1_dat_q, s1_dat_d;

  // Clear FSM: one zeroed word per cycle, clr_req ignored while clearing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    clr_busy_d = (state_d == S_CLEAR);
  end

  // Effective byte enables, conflict detection and same-port merged read word
  always_comb begin
    clearing_c  = (state_q == S_CLEAR);
    wr_a_c      = wren_a & ~clearing_c;
    wr_b_c      = wren_b & ~clearing_c;
    same_addr_c = (address_a == address_b);
    be_a_c      = wr_a_c ? byteena_a : '0;
    be_b_c      = wr_b_c ? byteena_b : '0;
    // Port A owns any byte both ports try to write
    if (same_addr_c) begin
      be_b_c = be_b_c & ~be_a_c;
    end
    collision_d = wr_a_c & wr_b_c & same_addr_c & (|(byteena_a & byteena_b));
    old_a_c = mem[address_a];
    old_b_c = mem[address_b];
    new_a_c = old_a_c;
    new_b_c = old_b_c;
    // New-data view shows the post-write value of the bytes this port wrote
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (be_a_c[i]) begin
        new_a_c[8*i +: 8] = data_a[8*i +: 8];
      end
      if (wr_b_c && byteena_b[i]) begin
        new_b_c[8*i +: 8] = (same_addr_c && be_a_c[i]) ? data_a[8*i +: 8] : data_b[8*i +: 8];
      end
    end
  end

  // First read stage: capture on rden, hold otherwise
  always_comb begin
    s1_vld_d = {rden_b, rden_a};
    s1_dat_d = s1_dat_q;
    if (rden_a) begin
      s1_dat_d[0] = (RDW_NEW != 0) ? new_a_c : old_a_c;
    end
    if (rden_b) begin
      s1_dat_d[1] = (RDW_NEW != 0) ? new_b_c : old_b_c;
    end
  end

  // Control and first read-stage registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_busy_q  <= 1'b0;
      collision_q <= 1'b0;
      s1_vld_q    <= '0;
      s1_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_busy_q  <= clr_busy_d;
      collision_q <= collision_d;
      s1_vld_q    <= s1_vld_d;
      s1_dat_q    <= s1_dat_d;
    end
  end

  // Memory array writes (contents survive reset)
  always_ff @(posedge clock) begin
    if (clearing_c) begin
      mem[cnt_q] <= '0;
    end
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (be_a_c[i]) begin
        mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
      if (be_b_c[i]) begin
        mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
      end
    end
  end

  // Optional second read stage; any RD_LAT other than 2 behaves as 1
  if (RD_LAT == 2) begin : g_lat2
    logic [1:0]             s2_vld_q, s2_vld_d;
    logic [1:0][DATA_W-1:0] s2_dat_q, s2_dat_d;

    // Advance data only behind a valid first stage so q holds otherwise
    always_comb begin
      s2_vld_d = s1_vld_q;
      s2_dat_d = s2_dat_q;
      for (int unsigned p = 0; p < 2; p++) begin
        if (s1_vld_q[p]) begin
          s2_dat_d[p] = s1_dat_q[p];
        end
      end
    end

    // Second read-stage registers
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s2_vld_q <= '0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s2_vld_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign q_a      = s2_dat_q[0];
    assign q_b      = s2_dat_q[1];
    assign qvalid_a = s2_vld_q[0];
    assign qvalid_b = s2_vld_q[1];
  end else begin : g_lat1
    assign q_a      = s1_dat_q[0];
    assign q_b      = s1_dat_q[1];
    assign qvalid_a = s1_vld_q[0];
    assign qvalid_b = s1_vld_q[1];
  end

  assign clr_busy  = clr_busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_vram_dp_be.sv
// Bench for vram_dp_be: two instances (RD_LAT=1/old-data and RD_LAT=2/new-data)
// share one stimulus stream and are checked against a word-level memory model.
module tb_vram_dp_be;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NVEC  = 14;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rden_a, wren_a, rden_b, wren_b, clr_req;
  logic [3:0]  byteena_a, byteena_b, address_a, address_b;
  logic [31:0] data_a, data_b;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        qv_a0, qv_b0, qv_a1, qv_b1, coll0, coll1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vram_dp_be #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(1), .RDW_NEW(0)) dut0 (
    .clock(clock), .reset(reset),
    .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a),
    .data_a(data_a), .q_a(q_a0), .qvalid_a(qv_a0),
    .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b),
    .data_b(data_b), .q_b(q_b0), .qvalid_b(qv_b0),
    .clr_req(clr_req), .clr_busy(busy0), .collision(coll0)
  );

  vram_dp_be #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(2), .RDW_NEW(1)) dut1 (
    .clock(clock), .reset(reset),
    .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a),
    .data_a(data_a), .q_a(q_a1), .qvalid_a(qv_a1),
    .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b),
    .data_b(data_b), .q_b(q_b1), .qvalid_b(qv_b1),
    .clr_req(clr_req), .clr_busy(busy1), .collision(coll1)
  );

  // Reference model state: word array, clear progress, expected outputs
  logic [31:0] mm [DEPTH];
  bit          m_clr;
  logic [3:0]  m_ptr;
  logic [31:0] eq [2][2];
  bit          ev [2][2];
  logic [31:0] pd [2];
  bit          pv [2];
  bit          ecoll, ebusy;

  typedef struct {
    bit          we_a, re_a;
    logic [3:0]  be_a;
    logic [7:0]  ad_a;
    logic [31:0] d_a;
    bit          we_b, re_b;
    logic [3:0]  be_b;
    logic [7:0]  ad_b;
    logic [31:0] d_b;
    logic [31:0] ea0, ea1, eb0, eb1;
    bit          ecol;
  } vec_t;

  vec_t        tv [NVEC];
  vec_t        v;
  bit          lat_v [6];
  logic [31:0] lat_d [6];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 1'b0;
    m_ptr = 4'd0;
    ecoll = 1'b0;
    ebusy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      pd[k] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        eq[k][p] = 32'h0;
        ev[k][p] = 1'b0;
      end
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model
  task automatic model_edge();
    logic [31:0] old_a, old_b;
    logic [31:0] rdn [2];
    bit          wa, wb;
    old_a = mm[address_a];
    old_b = mm[address_b];
    wa = wren_a && !m_clr;
    wb = wren_b && !m_clr;
    ecoll = wa && wb && (address_a == address_b) && ((byteena_a & byteena_b) != 4'h0);
    if (wb) mm[address_b] = merge(mm[address_b], data_b, byteena_b);
    if (wa) mm[address_a] = merge(mm[address_a], data_a, byteena_a);
    rdn[0] = wa ? merge(old_a, mm[address_a], byteena_a) : old_a;
    rdn[1] = wb ? merge(old_b, mm[address_b], byteena_b) : old_b;
    if (m_clr) begin
      mm[m_ptr] = 32'h0;
      if (m_ptr == 4'd15) m_clr = 1'b0;
      m_ptr = m_ptr + 4'd1;
    end else if (clr_req) begin
      m_clr = 1'b1;
      m_ptr = 4'd0;
    end
    ebusy = m_clr;
    ev[0][0] = rden_a;
    if (rden_a) eq[0][0] = old_a;
    ev[0][1] = rden_b;
    if (rden_b) eq[0][1] = old_b;
    for (int p = 0; p < 2; p++) begin
      ev[1][p] = pv[p];
      if (pv[p]) eq[1][p] = pd[p];
    end
    pv[0] = rden_a;
    pd[0] = rdn[0];
    pv[1] = rden_b;
    pd[1] = rdn[1];
  endtask

  task automatic check_all();
    cmp("q_a0", q_a0, eq[0][0]);
    cmp("qvalid_a0", 32'(qv_a0), 32'(ev[0][0]));
    cmp("q_b0", q_b0, eq[0][1]);
    cmp("qvalid_b0", 32'(qv_b0), 32'(ev[0][1]));
    cmp("q_a1", q_a1, eq[1][0]);
    cmp("qvalid_a1", 32'(qv_a1), 32'(ev[1][0]));
    cmp("q_b1", q_b1, eq[1][1]);
    cmp("qvalid_b1", 32'(qv_b1), 32'(ev[1][1]));
    cmp("collision0", 32'(coll0), 32'(ecoll));
    cmp("collision1", 32'(coll1), 32'(ecoll));
    cmp("clr_busy0", 32'(busy0), 32'(ebusy));
    cmp("clr_busy1", 32'(busy1), 32'(ebusy));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rden_a = 1'b0; wren_a = 1'b0; byteena_a = 4'h0; address_a = 4'h0; data_a = 32'h0;
    rden_b = 1'b0; wren_b = 1'b0; byteena_b = 4'h0; address_b = 4'h0; data_b = 32'h0;
    clr_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic write_a(input logic [3:0] ad, input logic [31:0] d);
    idle();
    wren_a = 1'b1; byteena_a = 4'hF; address_a = ad; data_a = d;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           we_a  re_a  be_a  ad_a   d_a           we_b  re_b  be_b  ad_b   d_b           ea0           ea1           eb0           eb1           ecol
    tv[0]  = '{1'b1, 1'b0, 4'hF, 8'h10, 32'h11223344, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tv[1]  = '{1'b1, 1'b0, 4'h5, 8'h10, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tv[2]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        1'b0, 1'b1, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h11BB33DD, 32'h11BB33DD, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 4'hF, 8'h07, 32'h00000001, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tv[4]  = '{1'b1, 1'b1, 4'hF, 8'h07, 32'h00000002, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h00000001, 32'h00000002, 32'h0,        32'h0,        1'b0};
    tv[5]  = '{1'b0, 1'b1, 4'h0, 8'h07, 32'h0,        1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h00000002, 32'h00000002, 32'h0,        32'h0,        1'b0};
    tv[6]  = '{1'b1, 1'b0, 4'hF, 8'h05, 32'h12345678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tv[7]  = '{1'b1, 1'b0, 4'h3, 8'h05, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h6, 8'h05, 32'h00000000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
    tv[8]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        1'b0, 1'b1, 4'h0, 8'h05, 32'h0,        32'h0,        32'h0,        32'h1200FFFF, 32'h1200FFFF, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 4'hF, 8'h09, 32'h00000099, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tv[10] = '{1'b1, 1'b0, 4'hF, 8'h09, 32'hCAFEF00D, 1'b0, 1'b1, 4'h0, 8'h09, 32'h0,        32'h0,        32'h0,        32'h00000099, 32'h00000099, 1'b0};
    tv[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        1'b0, 1'b1, 4'h0, 8'h09, 32'h0,        32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    tv[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 1'b1, 4'hF, 8'h03, 32'h00000055, 32'h0,        32'h0,        32'h00000000, 32'h00000055, 1'b0};
    tv[13] = '{1'b1, 1'b1, 4'h1, 8'h03, 32'h000000CD, 1'b1, 1'b1, 4'h8, 8'h03, 32'hAB000000, 32'h00000055, 32'h000000CD, 32'h00000055, 32'hAB000055, 1'b0};

    lat_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lat_d = '{32'h0, 32'h101, 32'h202, 32'h303, 32'h0, 32'h0};

    // Reset, then one full clear so every word has a known value
    do_reset();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (DEPTH) cycle();

    // Directed vectors: merge, read-during-write, collision, cross-port
    for (int i = 0; i < int'(NVEC); i++) begin
      v = tv[i];
      idle();
      wren_a = v.we_a; rden_a = v.re_a; byteena_a = v.be_a; address_a = v.ad_a[3:0]; data_a = v.d_a;
      wren_b = v.we_b; rden_b = v.re_b; byteena_b = v.be_b; address_b = v.ad_b[3:0]; data_b = v.d_b;
      cycle();
      if (v.re_a) begin
        cmp("tv_q_a_lat1", q_a0, v.ea0);
        cmp("tv_qvalid_a_lat1", 32'(qv_a0), 32'd1);
      end
      if (v.re_b) cmp("tv_q_b_lat1", q_b0, v.eb0);
      cmp("tv_collision0", 32'(coll0), 32'(v.ecol));
      cmp("tv_collision1", 32'(coll1), 32'(v.ecol));
      idle();
      cycle();
      if (v.re_a) begin
        cmp("tv_q_a_lat2", q_a1, v.ea1);
        cmp("tv_qvalid_a_lat2", 32'(qv_a1), 32'd1);
      end
      if (v.re_b) cmp("tv_q_b_lat2", q_b1, v.eb1);
      cmp("tv_collision_drop", 32'(coll0), 32'd0);
      cycle();
    end

    // Back-to-back reads on the two-cycle instance
    write_a(4'd1, 32'h101);
    write_a(4'd2, 32'h202);
    write_a(4'd3, 32'h303);
    begin
      int hi;
      hi = 0;
      for (int k = 0; k < 6; k++) begin
        idle();
        if (k < 3) begin
          rden_b = 1'b1;
          address_b = 4'(k + 1);
        end
        cycle();
        cmp("lat2_qvalid_b", 32'(qv_b1), 32'(lat_v[k]));
        if (lat_v[k]) cmp("lat2_q_b", q_b1, lat_d[k]);
        if (qv_b1) hi++;
      end
      cmp("lat2_qvalid_b_count", 32'(hi), 32'd3);
    end

    // Full clear with writes and a repeated request inside the busy window
    for (int i = 0; i < int'(DEPTH); i++) write_a(4'(i), 32'hC0DE0000 | 32'(i));
    idle();
    clr_req = 1'b1;
    cycle();
    begin
      int bcnt;
      bcnt = 0;
      for (int n = 0; n < 40; n++) begin
        if (!busy0) break;
        bcnt++;
        idle();
        wren_a = 1'b1; byteena_a = 4'hF; address_a = 4'($urandom); data_a = $urandom | 32'h1;
        wren_b = 1'b1; byteena_b = 4'hF; address_b = 4'($urandom); data_b = $urandom | 32'h1;
        rden_a = 1'($urandom_range(0, 1));
        clr_req = (n == 5) ? 1'b1 : 1'b0;
        cycle();
      end
      cmp("clear_busy_cycles", 32'(bcnt), 32'd16);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      idle();
      rden_a = 1'b1;
      address_a = 4'(i);
      cycle();
      cmp("clear_word_zero", q_a0, 32'h0);
    end

    // Reset after six clear cycles with a read in flight
    for (int i = 0; i < int'(DEPTH); i++) write_a(4'(i), 32'hA5000000 | 32'(i));
    idle();
    clr_req = 1'b1;
    cycle();
    idle();
    repeat (5) cycle();
    rden_b = 1'b1;
    address_b = 4'd15;
    cycle();
    do_reset();
    cmp("midclr_busy", 32'(busy0), 32'd0);
    idle();
    cycle();
    cmp("midclr_flush_qvalid_b", 32'(qv_b1), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      idle();
      rden_a = 1'b1;
      address_a = 4'(i);
      cycle();
      cmp("midclr_word", q_a0, (i < 6) ? 32'h0 : (32'hA5000000 | 32'(i)));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      rden_a = 1'($urandom_range(0, 1));
      wren_a = 1'($urandom_range(0, 1));
      byteena_a = 4'($urandom);
      address_a = 4'($urandom);
      data_a = $urandom;
      rden_b = 1'($urandom_range(0, 1));
      wren_b = 1'($urandom_range(0, 1));
      byteena_b = 4'($urandom);
      address_b = ($urandom_range(0, 3) == 0) ? address_a : 4'($urandom);
      data_b = $urandom;
      clr_req = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    idle();
    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
